lsu_ctrl: RTL

Load/store sequencer for the MEM stage of the RV32I pipeline. Turns MemRead/MemWrite plus funct3 and address from MEM into a valid/ready data-memory transaction, and stalls the pipeline while the transaction is outstanding. Generates store byte lanes and returns lane-aligned, sign- or zero-extended load data. Detects misaligned or illegal accesses, handles flush mid-transaction and enforces a bus timeout.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_align.sv | 43 ++++
 rtl/lsu_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and legality helpers for the MEM-stage load/store sequencer.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DRAIN,
      S_DONE
   } state_t;

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      logic res;
      res = 1'b0;
      case (funct3)
         F3_H, F3_HU: res = off[0];
         F3_W:        res = (off != 2'b00);
         default:     res = 1'b0;
      endcase
      return res;
   endfunction

   // Stores accept only B/H/W; loads reject the three unused encodings.
   function automatic logic is_illegal(input logic [2:0] funct3, input logic we);
      logic res;
      if (we)
         res = !(funct3 inside {F3_B, F3_H, F3_W});
      else
         res = (funct3 inside {3'b011, 3'b110, 3'b111});
      return res;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/replicated data and load extraction/extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] write_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rdata[{off, 3'b000} +: 8];
   assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      be        = 4'b1111;
      wdata     = write_data;
      load_data = rdata;
      case (funct3)
         F3_B, F3_BU: begin
            be        = 4'b0001 << off;
            wdata     = {4{write_data[7:0]}};
            load_data = (funct3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
         end
         F3_H, F3_HU: begin
            be        = off[1] ? 4'b1100 : 4'b0011;
            wdata     = {2{write_data[15:0]}};
            load_data = (funct3 == F3_H) ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
         end
         default: begin
            be        = 4'b1111;
            wdata     = write_data;
            load_data = rdata;
         end
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store sequencer: issues one valid/ready dmem transaction per
// legal access, stalls the pipeline meanwhile, and handles flush and timeout.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | no transaction; screen new access, capture fields
//   S_REQ   | dmem_req held with captured fields until dmem_gnt
//   S_WAIT  | load granted, waiting for dmem_rvalid
//   S_DRAIN | load was flushed after grant; swallow its rvalid
//   S_DONE  | release stall; pulse LoadValidM for loads
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [2:0]  funct3M,
   input  logic [31:0] AddrM,
   input  logic [31:0] WriteDataM,
   input  logic        FlushM,
   output logic        StallM,
   output logic [31:0] LoadDataM,
   output logic        LoadValidM,
   output logic        ExcM,
   output logic        BusErrM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata
);

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt;
   logic              r_we;
   logic [29:0]       r_addr;
   logic [2:0]        r_f3;
   logic [1:0]        r_off;
   logic [31:0]       r_wd;
   logic [31:0]       load_q;

   logic              acc, bad, tmo, capture, ld_capture;
   logic [3:0]        be_w;
   logic [31:0]       wdata_w, ld_w;

   assign acc = (MemReadM | MemWriteM) & ~FlushM;
   assign bad = is_illegal(funct3M, MemWriteM) | is_misaligned(funct3M, AddrM[1:0]);
   assign tmo = (cnt == CNT_W'(TIMEOUT - 1));

   // Steering works from the captured fields so the bus sees stable lanes.
   lsu_align u_align (
      .funct3     (r_f3),
      .off        (r_off),
      .write_data (r_wd),
      .rdata      (dmem_rdata),
      .be         (be_w),
      .wdata      (wdata_w),
      .load_data  (ld_w)
   );

   always_comb begin
      state_nx   = state;
      StallM     = 1'b0;
      LoadValidM = 1'b0;
      ExcM       = 1'b0;
      BusErrM    = 1'b0;
      capture    = 1'b0;
      ld_capture = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (acc) begin
               if (bad) begin
                  ExcM = 1'b1;
               end else begin
                  StallM   = 1'b1;
                  capture  = 1'b1;
                  state_nx = S_REQ;
               end
            end
         end
         S_REQ: begin
            StallM = 1'b1;
            if (dmem_gnt) begin
               if (r_we)        state_nx = S_DONE;
               else if (FlushM) state_nx = S_DRAIN;
               else             state_nx = S_WAIT;
            end else if (FlushM) begin
               state_nx = S_IDLE;
            end else if (tmo) begin
               BusErrM  = 1'b1;
               StallM   = 1'b0;
               state_nx = S_IDLE;
            end
         end
         S_WAIT: begin
            StallM = 1'b1;
            if (dmem_rvalid) begin
               if (FlushM) begin
                  state_nx = S_IDLE;
               end else begin
                  ld_capture = 1'b1;
                  state_nx   = S_DONE;
               end
            end else if (FlushM) begin
               state_nx = S_DRAIN;
            end else if (tmo) begin
               BusErrM  = 1'b1;
               StallM   = 1'b0;
               state_nx = S_IDLE;
            end
         end
         S_DRAIN: begin
            // A new access waits here so it never overlaps the stale response.
            StallM = acc;
            if (dmem_rvalid || tmo) state_nx = S_IDLE;
         end
         S_DONE: begin
            LoadValidM = ~r_we;
            state_nx   = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         r_we   <= 1'b0;
         r_addr <= '0;
         r_f3   <= '0;
         r_off  <= '0;
         r_wd   <= '0;
         load_q <= '0;
      end else begin
         state <= state_nx;
         if (state_nx != state)
            cnt <= '0;
         else if (state inside {S_REQ, S_WAIT, S_DRAIN})
            cnt <= cnt + CNT_W'(1);
         if (capture) begin
            r_we   <= MemWriteM;
            r_addr <= AddrM[31:2];
            r_f3   <= funct3M;
            r_off  <= AddrM[1:0];
            r_wd   <= WriteDataM;
         end
         if (ld_capture)
            load_q <= ld_w;
      end
   end

   assign dmem_req   = (state == S_REQ);
   assign dmem_we    = dmem_req & r_we;
   assign dmem_addr  = dmem_req ? {r_addr, 2'b00} : '0;
   assign dmem_be    = dmem_req ? be_w : '0;
   assign dmem_wdata = dmem_req ? wdata_w : '0;
   assign LoadDataM  = load_q;

endmodule
